// File: rtl/move_list_writer.sv
// move_list_writer: packs accepted moves from the move generator into 32-bit
// words in the shared RAM starting at BASE_ADDR, then writes a summary word
// (overflow flag and move count) to COUNT_ADDR and raises done.
module move_list_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int BASE_ADDR  = 16,
  parameter int COUNT_ADDR = 1,
  parameter int MAX_MOVES  = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  move_valid,
  output logic                  move_ready,
  input  logic [5:0]            move_from,
  input  logic [5:0]            move_to,
  input  logic [3:0]            move_piece,
  input  logic [3:0]            move_capture,
  input  logic [2:0]            move_promo,
  input  logic                  gen_done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_writedata,
  output logic [7:0]            move_count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE_COUNT, DONE} state_t;

  localparam logic [7:0]            MAX_CNT  = 8'(MAX_MOVES);
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] COUNT_A  = ADDR_WIDTH'(COUNT_ADDR);

  state_t state;
  logic   hs;
  logic   room;

  function automatic logic [DATA_WIDTH-1:0] pack_move(
    input logic [5:0] from_sq,
    input logic [5:0] to_sq,
    input logic [3:0] piece,
    input logic [3:0] capture,
    input logic [2:0] promo
  );
    logic [DATA_WIDTH-1:0] w;
    w        = '0;
    w[5:0]   = from_sq;
    w[11:6]  = to_sq;
    w[15:12] = piece;
    w[19:16] = capture;
    w[22:20] = promo;
    return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pack_summary(
    input logic       ovf,
    input logic [7:0] cnt
  );
    logic [DATA_WIDTH-1:0] w;
    w                 = '0;
    w[DATA_WIDTH-1]   = ovf;
    w[7:0]            = cnt;
    return w;
  endfunction

  // move_ready is only ever high in ACCEPT, so this is the accept handshake
  assign hs   = move_valid && move_ready && (state == ACCEPT);
  assign room = (move_count < MAX_CNT);

  // Control FSM with registered RAM write port and status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      move_ready    <= 1'b0;
      ram_address   <= '0;
      ram_write     <= 1'b0;
      ram_writedata <= '0;
      move_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      ram_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCEPT;
            move_ready <= 1'b1;
            move_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ACCEPT: begin
          if (hs) begin
            if (room) begin
              ram_write     <= 1'b1;
              ram_address   <= BASE_A + ADDR_WIDTH'(move_count);
              ram_writedata <= pack_move(move_from, move_to, move_piece,
                                         move_capture, move_promo);
              move_count    <= move_count + 8'd1;
            end else begin
              overflow <= 1'b1;
            end
          end
          if (gen_done) begin
            move_ready <= 1'b0;
            if (hs) begin
              // the last move's count/overflow update lands this edge, so
              // the summary is built one cycle later
              state <= WRITE_COUNT;
            end else begin
              ram_write     <= 1'b1;
              ram_address   <= COUNT_A;
              ram_writedata <= pack_summary(overflow, move_count);
              state         <= DONE;
            end
          end
        end
        WRITE_COUNT: begin
          ram_write     <= 1'b1;
          ram_address   <= COUNT_A;
          ram_writedata <= pack_summary(overflow, move_count);
          state         <= DONE;
        end
        DONE: begin
          if (start) begin
            state      <= ACCEPT;
            move_ready <= 1'b1;
            move_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
          end else begin
            // done follows the summary write cycle
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_list_writer.sv
// Testbench for move_list_writer: scoreboard of expected RAM writes, checked
// by a monitor on the falling edge, plus per-scenario status checks.
module tb_move_list_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        move_valid;
  logic        move_ready;
  logic [5:0]  move_from;
  logic [5:0]  move_to;
  logic [3:0]  move_piece;
  logic [3:0]  move_capture;
  logic [2:0]  move_promo;
  logic        gen_done;
  logic [14:0] ram_address;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [7:0]  move_count;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int exp_count = 0;
  logic exp_ovf = 1'b0;
  logic [46:0] sb[$];

  move_list_writer dut (
    .clk(clk), .reset(reset), .start(start),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_from(move_from), .move_to(move_to), .move_piece(move_piece),
    .move_capture(move_capture), .move_promo(move_promo),
    .gen_done(gen_done),
    .ram_address(ram_address), .ram_write(ram_write),
    .ram_writedata(ram_writedata),
    .move_count(move_count), .busy(busy), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Write monitor: every write must match the oldest expected entry
  always @(negedge clk) begin
    logic [46:0] e;
    if (ram_write === 1'b1) begin
      wr_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h (none expected)",
                 ram_address, ram_writedata);
      end else begin
        e = sb.pop_front();
        if ({ram_address, ram_writedata} !== e) begin
          errors++;
          $display("FAIL ram_write got addr=%0d data=%h want addr=%0d data=%h",
                   ram_address, ram_writedata, e[46:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] ref_word(input logic [5:0] f, input logic [5:0] t,
                                           input logic [3:0] p, input logic [3:0] c,
                                           input logic [2:0] pr);
    return {9'd0, pr, c, p, t, f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; move_valid = 0; gen_done = 0;
    move_from = 0; move_to = 0; move_piece = 0; move_capture = 0; move_promo = 0;
  endtask

  task automatic push_summary();
    sb.push_back({15'd1, exp_ovf, 23'd0, exp_count[7:0]});
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d want 0", name, sb.size());
    end
  endtask

  task automatic do_start(input string name);
    start = 1;
    step();
    start = 0;
    exp_count = 0;
    exp_ovf   = 1'b0;
    checks++;
    if ({busy, move_ready, done, overflow, move_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL %s_start busy=%b ready=%b done=%b ovf=%b cnt=%0d want 1 1 0 0 0",
               name, busy, move_ready, done, overflow, move_count);
    end
  endtask

  task automatic send(input logic [5:0] f, input logic [5:0] t, input logic [3:0] p,
                      input logic [3:0] c, input logic [2:0] pr, input logic gd,
                      input logic [31:0] word);
    logic stored;
    move_valid = 1; move_from = f; move_to = t; move_piece = p;
    move_capture = c; move_promo = pr; gen_done = gd;
    stored = (exp_count < 100);
    if (stored) begin
      sb.push_back({15'(16 + exp_count), word});
      exp_count++;
    end else begin
      exp_ovf = 1'b1;
    end
    if (gd) push_summary();
    step();
    move_valid = 0; gen_done = 0;
    checks++;
    if (move_count !== exp_count[7:0] || overflow !== exp_ovf || ram_write !== stored) begin
      errors++;
      $display("FAIL send cnt=%0d ovf=%b wr=%b want cnt=%0d ovf=%b wr=%b",
               move_count, overflow, ram_write, exp_count, exp_ovf, stored);
    end
  endtask

  task automatic finish_list(input string name);
    gen_done = 1;
    push_summary();
    step();
    gen_done = 0;
    checks++;
    if (done !== 1'b0 || ram_write !== 1'b1) begin
      errors++;
      $display("FAIL %s_summary_cycle done=%b wr=%b want 0 1", name, done, ram_write);
    end
    step();
    checks++;
    if ({done, busy, move_ready} !== 3'b100) begin
      errors++;
      $display("FAIL %s_done done=%b busy=%b ready=%b want 1 0 0",
               name, done, busy, move_ready);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); move_valid = 1'($urandom); gen_done = 1'($urandom);
      move_from = 6'($urandom); move_to = 6'($urandom);
      step();
    end
    checks++;
    if ({ram_address, ram_write, ram_writedata, move_count, busy, done, overflow, move_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs addr=%0d wr=%b data=%h cnt=%0d busy=%b done=%b ovf=%b ready=%b want all 0",
               ram_address, ram_write, ram_writedata, move_count, busy, done, overflow, move_ready);
    end
    idle_inputs();
    reset = 1;
    move_valid = 1;
    repeat (3) step();
    move_valid = 0;
    checks++;
    if ({busy, move_ready, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle busy=%b ready=%b done=%b want 0 0 0", busy, move_ready, done);
    end
  endtask

  task automatic test_three_moves();
    int w0;
    do_start("three");
    w0 = wr_count;
    send(6'd12, 6'd28, 4'd1, 4'd0, 3'd0, 1'b0, 32'h0000170C);
    send(6'd6,  6'd21, 4'd3, 4'd0, 3'd0, 1'b0, 32'h00003546);
    send(6'd11, 6'd27, 4'd1, 4'd1, 3'd0, 1'b0, 32'h000116CB);
    checks++;
    if (wr_count - w0 != 2) begin
      errors++;
      $display("FAIL three_consecutive writes_seen=%0d want 2", wr_count - w0);
    end
    sb.push_back({15'd1, 32'h00000003});
    gen_done = 1;
    step();
    gen_done = 0;
    step();
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL three_done done=%b busy=%b want 1 0", done, busy);
    end
    drain("three");
  endtask

  task automatic test_gapped();
    int w0;
    logic [5:0] pat;
    pat = 6'b101101;
    do_start("gapped");
    w0 = wr_count;
    for (int i = 0; i < 6; i++) begin
      if (pat[5 - i]) begin
        send(6'(i + 1), 6'(40 + i), 4'(i + 2), 4'd0, 3'(i % 5), 1'b0,
             ref_word(6'(i + 1), 6'(40 + i), 4'(i + 2), 4'd0, 3'(i % 5)));
      end else begin
        move_from = 6'd63; move_to = 6'd63;
        step();
      end
    end
    drain("gapped");
    checks++;
    if (wr_count - w0 != 4) begin
      errors++;
      $display("FAIL gapped_writes got=%0d want 4", wr_count - w0);
    end
    finish_list("gapped");
    drain("gapped_sum");
  endtask

  task automatic test_overflow();
    do_start("ovf");
    for (int i = 0; i < 102; i++) begin
      send(6'(i), 6'(63 - (i % 64)), 4'(i % 16), 4'((i * 3) % 16), 3'(i % 8), 1'b0,
           ref_word(6'(i), 6'(63 - (i % 64)), 4'(i % 16), 4'((i * 3) % 16), 3'(i % 8)));
    end
    checks++;
    if (move_count !== 8'd100 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_state cnt=%0d ovf=%b want 100 1", move_count, overflow);
    end
    drain("ovf");
    sb.push_back({15'd1, 32'h80000064});
    gen_done = 1;
    step();
    gen_done = 0;
    step();
    drain("ovf_sum");
  endtask

  task automatic test_coincident_done();
    do_start("coin");
    send(6'd1, 6'd2, 4'd5, 4'd0, 3'd0, 1'b0, ref_word(6'd1, 6'd2, 4'd5, 4'd0, 3'd0));
    send(6'd3, 6'd4, 4'd6, 4'd9, 3'd2, 1'b1, ref_word(6'd3, 6'd4, 4'd6, 4'd9, 3'd2));
    step();
    checks++;
    if (ram_write !== 1'b1 || ram_writedata !== 32'h00000002 || done !== 1'b0) begin
      errors++;
      $display("FAIL coin_summary wr=%b data=%h done=%b want 1 00000002 0",
               ram_write, ram_writedata, done);
    end
    step();
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL coin_done done=%b busy=%b want 1 0", done, busy);
    end
    drain("coin");
  endtask

  task automatic test_reset_midlist();
    do_start("mid");
    for (int i = 0; i < 5; i++)
      send(6'(10 + i), 6'(20 + i), 4'd2, 4'd0, 3'd0, 1'b0,
           ref_word(6'(10 + i), 6'(20 + i), 4'd2, 4'd0, 3'd0));
    drain("mid");
    move_valid = 1; move_from = 6'd50;
    reset = 0;
    step();
    reset = 1;
    move_valid = 0;
    checks++;
    if ({move_count, busy, ram_write, move_ready} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset cnt=%0d busy=%b wr=%b ready=%b want 0 0 0 0",
               move_count, busy, ram_write, move_ready);
    end
    gen_done = 1;
    repeat (3) step();
    gen_done = 0;
    drain("mid_nosum");
    do_start("mid_restart");
    send(6'd33, 6'd41, 4'd4, 4'd2, 3'd1, 1'b0, ref_word(6'd33, 6'd41, 4'd4, 4'd2, 3'd1));
    finish_list("mid_restart");
    drain("mid_restart");
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_three_moves();
    test_gapped();
    test_overflow();
    test_coincident_done();
    test_reset_midlist();
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
